// File: rtl/umi_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : umi_port_arbiter
// Description : Per-output-port UMI arbiter with one-hot grant, transaction
//               lock until eom, fixed/round-robin modes, masking and
//               starvation promotion.
// Revision    : 1.0 - initial release
// ============================================================================
module umi_port_arbiter #(
    parameter int N      = 4,
    parameter int STARVE = 15,
    parameter int SW     = $clog2(STARVE + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   arbmode,
    input  logic [N-1:0] arbmask,
    input  logic [N-1:0] umi_in_request,
    input  logic [N-1:0] umi_in_eom,
    input  logic         umi_out_ready,
    output logic [N-1:0] grant,
    output logic         umi_out_valid,
    output logic [N-1:0] umi_in_ready,
    output logic         locked
);

    localparam int PW = $clog2(N);
    // Keep counters at least one bit wide so STARVE=0 still elaborates.
    localparam int CW = (SW < 1) ? 1 : SW;
    localparam logic [CW-1:0] C_STARVE = CW'(STARVE);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_lockvec;
    logic [PW-1:0]   r_ptr;
    logic [CW-1:0]   r_cnt [N];

    logic [N-1:0]    w_mreq;
    logic [N-1:0]    w_starved;
    logic [N-1:0]    w_sel;
    logic [PW-1:0]   w_gidx;
    logic [PW-1:0]   w_ptr_next;
    logic            w_xfer;
    logic            w_eom;
    logic            w_unused;

    assign w_unused = arbmode[1];
    assign w_mreq   = umi_in_request & ~arbmask;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_starve
            assign w_starved[gi] = (STARVE != 0) && (r_cnt[gi] == C_STARVE) && w_mreq[gi];
        end
    endgenerate

    // Loops run from the far end so the last match written wins: that is the
    // lowest index (or the nearest position after ptr in round-robin).
    always_comb begin
        w_sel = '0;
        if (|w_starved) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (w_starved[i]) begin
                    w_sel    = '0;
                    w_sel[i] = 1'b1;
                end
            end
        end else if (!arbmode[0]) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (w_mreq[i]) begin
                    w_sel    = '0;
                    w_sel[i] = 1'b1;
                end
            end
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                if (w_mreq[(int'(r_ptr) + k) % N]) begin
                    w_sel = '0;
                    w_sel[(int'(r_ptr) + k) % N] = 1'b1;
                end
            end
        end
    end

    assign grant         = (r_state == S_LOCKED) ? r_lockvec : w_sel;
    assign umi_out_valid = (r_state == S_LOCKED) ? |(r_lockvec & umi_in_request) : |w_sel;
    assign umi_in_ready  = grant & {N{umi_out_ready}};
    assign locked        = (r_state == S_LOCKED);
    assign w_xfer        = umi_out_valid & umi_out_ready;

    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) w_gidx = PW'(i);
        end
    end

    assign w_eom      = umi_in_eom[w_gidx];
    assign w_ptr_next = (w_gidx == PW'(N - 1)) ? '0 : w_gidx + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_lockvec <= '0;
            r_ptr     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        if (!w_eom) begin
                            r_state   <= S_LOCKED;
                            r_lockvec <= grant;
                        end else if (arbmode[0]) begin
                            r_ptr <= w_ptr_next;
                        end
                    end
                end
                S_LOCKED: begin
                    if (w_xfer && w_eom) begin
                        r_state   <= S_IDLE;
                        r_lockvec <= '0;
                        if (arbmode[0]) r_ptr <= w_ptr_next;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_lockvec <= '0;
                end
            endcase
        end
    end

    // Wait counters run in both states and saturate at STARVE.
    generate
        for (gi = 0; gi < N; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_cnt[gi] <= '0;
                end else if (!w_mreq[gi] || (grant[gi] && w_xfer)) begin
                    r_cnt[gi] <= '0;
                end else if (r_cnt[gi] < C_STARVE) begin
                    r_cnt[gi] <= r_cnt[gi] + 1'b1;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_umi_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_umi_port_arbiter
// Description : Self-checking bench; two arbiters (STARVE=0 and STARVE=3)
//               share stimulus and are compared against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_umi_port_arbiter;

    logic       clk;
    logic       reset;
    logic [1:0] arbmode;
    logic [3:0] arbmask;
    logic [3:0] req;
    logic [3:0] eom;
    logic       out_ready;

    logic [3:0] grant_a, grant_b, inrdy_a, inrdy_b;
    logic       valid_a, valid_b, locked_a, locked_b;

    int n_total = 0;
    int n_bad   = 0;

    // Model state: lock owner (-1 = idle), rr pointer, wait counters.
    int c_starve [2] = '{0, 3};
    int m_lock   [2];
    int m_ptr    [2];
    int m_cnt    [2][4];

    umi_port_arbiter #(.N(4), .STARVE(0)) u_dut_a (
        .clk(clk), .reset(reset), .arbmode(arbmode), .arbmask(arbmask),
        .umi_in_request(req), .umi_in_eom(eom), .umi_out_ready(out_ready),
        .grant(grant_a), .umi_out_valid(valid_a), .umi_in_ready(inrdy_a),
        .locked(locked_a)
    );

    umi_port_arbiter #(.N(4), .STARVE(3)) u_dut_b (
        .clk(clk), .reset(reset), .arbmode(arbmode), .arbmask(arbmask),
        .umi_in_request(req), .umi_in_eom(eom), .umi_out_ready(out_ready),
        .grant(grant_b), .umi_out_valid(valid_b), .umi_in_ready(inrdy_b),
        .locked(locked_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input int m);
        logic [3:0] mr;
        mr = req & ~arbmask;
        if (m_lock[m] >= 0) return m_lock[m];
        for (int i = 0; i < 4; i++)
            if (c_starve[m] != 0 && m_cnt[m][i] == c_starve[m] && mr[i]) return i;
        if (!arbmode[0]) begin
            for (int i = 0; i < 4; i++) if (mr[i]) return i;
        end else begin
            for (int k = 0; k < 4; k++) if (mr[(m_ptr[m] + k) % 4]) return (m_ptr[m] + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic exp_valid(input int m);
        int g;
        g = pick(m);
        if (g < 0) return 1'b0;
        if (m_lock[m] >= 0) return req[g];
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_lock[m] = -1;
            m_ptr[m]  = 0;
            for (int i = 0; i < 4; i++) m_cnt[m][i] = 0;
        end
    endtask

    task automatic model_update(input int m);
        int   g;
        logic x;
        logic [3:0] mr;
        g  = pick(m);
        x  = exp_valid(m) && out_ready;
        mr = req & ~arbmask;
        for (int i = 0; i < 4; i++) begin
            if (!mr[i] || (g == i && x)) m_cnt[m][i] = 0;
            else if (m_cnt[m][i] < c_starve[m]) m_cnt[m][i]++;
        end
        if (x) begin
            if (m_lock[m] < 0 && !eom[g]) begin
                m_lock[m] = g;
            end else if (eom[g]) begin
                m_lock[m] = -1;
                if (arbmode[0]) m_ptr[m] = (g + 1) % 4;
            end
        end
    endtask

    task automatic check_outputs();
        for (int m = 0; m < 2; m++) begin
            int g;
            logic [3:0] eg;
            g  = pick(m);
            eg = (g >= 0) ? 4'(1 << g) : 4'b0000;
            chk($sformatf("grant%0d", m),  (m == 0) ? grant_a  : grant_b,  eg);
            chk($sformatf("valid%0d", m),  (m == 0) ? valid_a  : valid_b,  exp_valid(m));
            chk($sformatf("inrdy%0d", m),  (m == 0) ? inrdy_a  : inrdy_b,  out_ready ? eg : 4'b0000);
            chk($sformatf("locked%0d", m), (m == 0) ? locked_a : locked_b, m_lock[m] >= 0);
        end
    endtask

    task automatic step(input logic [3:0] rq, input logic [3:0] eo, input logic [3:0] mk,
                        input logic [1:0] md, input logic rdy, input logic rs,
                        output logic [3:0] ga, output logic [3:0] gb, output logic lka);
        @(negedge clk);
        req = rq; eom = eo; arbmask = mk; arbmode = md; out_ready = rdy; reset = rs;
        #1;
        ga  = grant_a;
        gb  = grant_b;
        lka = locked_a;
        check_outputs();
        @(posedge clk);
        if (rs) model_reset();
        else begin
            model_update(0);
            model_update(1);
        end
    endtask

    initial begin
        logic [3:0] ga, gb;
        logic       lk;
        logic [3:0] rr_seq [5];
        logic [3:0] st_seq [5];
        logic [1:0] md;
        rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        st_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b1000, 4'b0001};
        req = '0; eom = '0; arbmask = '0; arbmode = '0; out_ready = 1'b0; reset = 1'b1;
        model_reset();

        // Reset state with no requests.
        step(4'b0000, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b1, ga, gb, lk);
        step(4'b0000, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, ga, gb, lk);
        chk("idle_grant", ga, 4'b0000);

        // Fixed priority, promotion disabled: input 1 always wins over 3.
        for (int c = 0; c < 6; c++) begin
            step(4'b1010, 4'b1111, 4'b0000, 2'b00, 1'b1, 1'b0, ga, gb, lk);
            chk("fixed_a", ga, 4'b0010);
        end

        // Round-robin sweep with pointer wrap.
        step(4'b0000, 4'b0000, 4'b0000, 2'b01, 1'b1, 1'b1, ga, gb, lk);
        for (int c = 0; c < 5; c++) begin
            step(4'b1111, 4'b1111, 4'b0000, 2'b01, 1'b1, 1'b0, ga, gb, lk);
            chk("rr_seq", ga, rr_seq[c]);
        end

        // Three-flit packet from input 2 with a ready stall mid-packet.
        step(4'b0000, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b1, ga, gb, lk);
        step(4'b0100, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, ga, gb, lk);
        chk("lock_f1", {lk, ga}, 5'b00100);
        step(4'b0101, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, ga, gb, lk);
        chk("lock_stall", {lk, ga}, 5'b10100);
        step(4'b0101, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, ga, gb, lk);
        chk("lock_f2", {lk, ga}, 5'b10100);
        step(4'b0101, 4'b0100, 4'b0000, 2'b00, 1'b1, 1'b0, ga, gb, lk);
        chk("lock_f3", {lk, ga}, 5'b10100);
        step(4'b0001, 4'b0001, 4'b0000, 2'b00, 1'b1, 1'b0, ga, gb, lk);
        chk("lock_next", {lk, ga}, 5'b00001);

        // Mask applied mid-packet does not break the lock.
        step(4'b0100, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, ga, gb, lk);
        step(4'b0101, 4'b0000, 4'b0100, 2'b00, 1'b1, 1'b0, ga, gb, lk);
        chk("mask_hold", {lk, ga}, 5'b10100);
        step(4'b0101, 4'b0100, 4'b0100, 2'b00, 1'b1, 1'b0, ga, gb, lk);
        chk("mask_eom", ga, 4'b0100);
        step(4'b0100, 4'b1111, 4'b0100, 2'b00, 1'b1, 1'b0, ga, gb, lk);
        chk("mask_block", ga, 4'b0000);

        // Starvation promotion on the STARVE=3 instance.
        step(4'b0000, 4'b0000, 4'b0000, 2'b00, 1'b1, 1'b1, ga, gb, lk);
        for (int c = 0; c < 5; c++) begin
            step(4'b1001, 4'b1111, 4'b0000, 2'b00, 1'b1, 1'b0, ga, gb, lk);
            chk("starve_b", gb, st_seq[c]);
            chk("starve_a", ga, 4'b0001);
        end

        // Reset while locked.
        step(4'b0010, 4'b0000, 4'b0000, 2'b01, 1'b1, 1'b0, ga, gb, lk);
        step(4'b0110, 4'b0000, 4'b0000, 2'b01, 1'b1, 1'b0, ga, gb, lk);
        chk("pre_rst_lock", lk, 1'b1);
        step(4'b0110, 4'b0000, 4'b0000, 2'b01, 1'b1, 1'b1, ga, gb, lk);
        step(4'b0110, 4'b0000, 4'b0000, 2'b01, 1'b1, 1'b0, ga, gb, lk);
        chk("post_rst", {lk, ga}, 5'b00010);

        // Randomized traffic against the model.
        md = 2'b00;
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] rq, eo, mk;
            if ($urandom_range(0, 49) == 0) md = 2'($urandom);
            for (int i = 0; i < 4; i++) begin
                rq[i] = ($urandom_range(0, 9) < 6);
                eo[i] = ($urandom_range(0, 2) == 0);
                mk[i] = ($urandom_range(0, 7) == 0);
            end
            step(rq, eo, mk, md, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 99) == 0, ga, gb, lk);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/umi_port_arbiter.md
Name: umi_port_arbiter

Overview:
- Per-output-port arbiter for the UMI switch. One instance sits in front of each output port mux.
- Picks one of N requesters and drives a one-hot grant, which also serves as the mux select.
- Holds the grant for a whole multi-flit transaction, until the flit with eom set is accepted.
- Supports fixed-priority and round-robin modes, per-path masking, and starvation promotion.

Parameters:
- N, 4, number of requesting input ports (N >= 2)
- STARVE, 15, cycles a requester may wait before promotion; 0 disables promotion
- SW, $clog2(STARVE+1), starvation counter width (derived)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- arbmode  input  2  bit0: 0=fixed priority, 1=round-robin; bit1 reserved, ignored
- arbmask  input  N  1=masked; masks only new arbitration, never a locked transaction
- umi_in_request  input  N  per-input request (valid) for this port
- umi_in_eom  input  N  per-input end-of-message bit of the presented flit
- umi_out_ready  input  1  downstream ready
- grant  output  N  one-hot grant / mux select; all zero when idle
- umi_out_valid  output  1  flit presented downstream
- umi_in_ready  output  N  per-input ready
- locked  output  1  mid-transaction hold active

Behaviour:
- Signal definitions:
  - mreq = umi_in_request & ~arbmask.
  - xfer = umi_out_valid & umi_out_ready.
  - gidx = index of the set bit in grant.
- Outputs are combinational from registered state plus inputs. Zero-cycle latency from request to grant.
- Registered state is: fsm (IDLE/LOCKED), lockvec[N], ptr (0..N-1), and starve counters cnt[i].
- Reset (synchronous, clk edge with reset=1):
  - fsm=IDLE, lockvec=0, ptr=0, all cnt=0.
  - With no requests: grant=0, umi_out_valid=0, umi_in_ready=0, locked=0.
  - Reset asserted mid-transaction abandons the lock at that edge.
- IDLE, grant selection:
  - Let starved[i] = (STARVE!=0) & (cnt[i]==STARVE) & mreq[i].
  - If any starved bit is set: grant the lowest-index starved requester, overriding the mode.
  - Else if arbmode[0]=0: grant the lowest-index set bit of mreq.
  - Else: grant the first set bit of mreq searching ptr, ptr+1, ... N-1, 0, ... (wrap-around).
  - mreq=0 -> grant=0.
- IDLE, outputs:
  - umi_out_valid = |grant.
  - umi_in_ready = grant & {N{umi_out_ready}}.
  - locked=0.
- IDLE, transitions:
  - On xfer with umi_in_eom[gidx]=0: fsm->LOCKED, lockvec<=grant.
  - On xfer with eom=1: stay IDLE.
  - In round-robin mode the xfer with eom=1 also sets ptr<=(gidx+1) mod N.
- LOCKED, outputs:
  - grant=lockvec, independent of arbmask and of other requests.
  - umi_out_valid = |(lockvec & umi_in_request), using the raw request.
  - umi_in_ready = lockvec & {N{umi_out_ready}}.
  - locked=1.
- LOCKED, transitions:
  - Locked requester drops its request: the grant is held and valid=0. No other requester is served.
  - On xfer with eom=1: fsm->IDLE, lockvec<=0. In round-robin mode, ptr<=(gidx+1) mod N.
  - The next arbitration happens combinationally in the following cycle (one idle-free turnaround; back-to-back packets from different inputs are allowed).
- ptr updates only in round-robin mode. A mode change takes effect at the next IDLE selection and never breaks a lock.
- Starvation counters, per input i, evaluated every cycle:
  - If !mreq[i] or (grant[i] & xfer): cnt<=0.
  - Else if cnt<STARVE: cnt<=cnt+1.
  - Saturates at STARVE, with no wrap.
  - Counters also advance in LOCKED for waiting inputs. Promotion takes effect at the next IDLE selection.
- Simultaneous events: xfer with eom=1 and a new request in the same cycle -> the new request is considered next cycle using the updated ptr.
- Invariants: grant is always one-hot or zero; umi_in_ready is never set for a non-granted input.

Test Plan:
- N=4, fixed mode, STARVE=0, requests 4'b1010 held, single-flit eom=1, out_ready=1 -> grant=4'b0010 every cycle; input 3 never served; counters unused.
- N=4, round-robin, requests 4'b1111 held, eom=1, out_ready=1 -> grant sequence 0001,0010,0100,1000,0001; ptr wraps from 3 to 0.
- Lock: input 2 sends a 3-flit packet (eom=0,0,1) while input 0 also requests; out_ready low for one cycle in the middle -> grant stays 4'b0100 for all 3 flits; locked=1 from after flit 1 until the eom flit is accepted; input 0 granted the next cycle.
- Mask mid-packet: arbmask[2] set after flit 1 of input 2 -> lock kept and packet completes; afterwards input 2 is not granted while masked.
- Starvation: fixed mode, STARVE=3, inputs 0 and 3 requesting continuously with eom=1 -> cnt[3] reaches 3 after 3 cycles; input 3 is granted on the 4th cycle; then cnt[3]=0 and input 0 resumes.
- Reset mid-lock: synchronous reset while locked=1 -> next cycle locked=0, ptr=0, counters 0; with requests 4'b0110 in round-robin mode, grant=4'b0010.
